// File: rtl/mem_arbiter.sv
// Arbitrates the single external memory port between the fetch and load/store requesters.
// Round-robin grant from idle; a swap lock keeps the bus on the load/store side between phases.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic              ls_lock,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              locked
);

    typedef enum logic [1:0] {IDLE, IF_BUSY, LS_BUSY, LOCKED} state_t;

    state_t            state_q, state_d;
    logic              last_ls_q;
    logic              if_req_m, ls_req_m;
    logic              grant_if, grant_ls, done;
    logic [ADDR_W-1:0] addr_sel;
    logic [3:0]        be_d;
    logic [DATA_W-1:0] wdata_d;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   byte_en = 4'b0001 << a;
            2'b01:   byte_en = a[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] lane_rep(input logic [1:0] size, input logic [DATA_W-1:0] wd);
        case (size)
            2'b00:   lane_rep = {4{wd[7:0]}};
            2'b01:   lane_rep = {2{wd[15:0]}};
            default: lane_rep = wd;
        endcase
    endfunction

    // A requester whose ready is high this cycle is still holding req; mask it to avoid a re-grant.
    assign if_req_m = if_req & ~if_ready;
    assign ls_req_m = ls_req & ~ls_ready;
    assign done     = mem_req & mem_ack;

    // State register plus the registered memory-side outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_ls_q <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= '0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
            if_ready  <= 1'b0;
            ls_ready  <= 1'b0;
            locked    <= 1'b0;
        end else begin
            state_q  <= state_d;
            if_ready <= 1'b0;
            ls_ready <= 1'b0;
            if (grant_if || grant_ls) begin
                mem_req   <= 1'b1;
                mem_we    <= grant_ls & ls_we;
                mem_addr  <= {addr_sel[ADDR_W-1:2], 2'b00};
                mem_be    <= be_d;
                mem_wdata <= wdata_d;
                last_ls_q <= grant_ls;
            end else if (done) begin
                mem_req <= 1'b0;
                if (state_q == IF_BUSY) begin
                    if_ready <= 1'b1;
                    if_rdata <= mem_rdata;
                end else begin
                    ls_ready <= 1'b1;
                    ls_rdata <= mem_rdata;
                    locked   <= ls_lock;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_if = 1'b0;
        grant_ls = 1'b0;
        case (state_q)
            IDLE: begin
                if (if_req_m && ls_req_m) begin
                    grant_if = last_ls_q;
                    grant_ls = ~last_ls_q;
                end else begin
                    grant_if = if_req_m;
                    grant_ls = ls_req_m;
                end
            end
            LOCKED:  grant_ls = ls_req_m;
            IF_BUSY: if (done) state_d = IDLE;
            LS_BUSY: if (done) state_d = ls_lock ? LOCKED : IDLE;
            default: state_d = IDLE;
        endcase
        if (grant_if) state_d = IF_BUSY;
        if (grant_ls) state_d = LS_BUSY;
    end

    always_comb begin
        addr_sel = grant_ls ? ls_addr : if_addr;
        be_d     = grant_ls ? byte_en(ls_size, addr_sel[1:0]) : 4'b1111;
        wdata_d  = grant_ls ? lane_rep(ls_size, ls_wdata) : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: handshake timing, round robin, lane formation, swap lock,
// wait states and asynchronous reset mid-access.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, ls_req, ls_we, ls_lock, mem_ack;
    logic [1:0]  ls_size;
    logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
    logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
    logic        if_ready, ls_ready, mem_req, mem_we, locked;
    logic [3:0]  mem_be;

    int n_cmp = 0;
    int n_bad = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_lock(ls_lock),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_ready(ls_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; if_req = 0; ls_req = 0; ls_we = 0; ls_lock = 0; mem_ack = 0;
        ls_size = 2'b10; if_addr = 0; ls_addr = 0; ls_wdata = 0; mem_rdata = 0;
        tick(); tick();
        chk("rst_mem_req", {31'd0, mem_req}, 0);
        chk("rst_locked", {31'd0, locked}, 0);
        chk("rst_readies", {30'd0, if_ready, ls_ready}, 0);
        chk("rst_mem_be", {28'd0, mem_be}, 0);
        rst = 1'b0;
        tick();

        // 1: fetch, ack one cycle after mem_req rises
        if_req = 1; if_addr = 32'h104;
        tick();
        chk("t1_mem_req", {31'd0, mem_req}, 1);
        chk("t1_mem_be", {28'd0, mem_be}, 4'hF);
        chk("t1_mem_we", {31'd0, mem_we}, 0);
        chk("t1_mem_addr", mem_addr, 32'h104);
        tick();
        chk("t1_no_early_ready", {31'd0, if_ready}, 0);
        mem_ack = 1; mem_rdata = 32'hDEADBEEF;
        tick();
        chk("t1_if_ready", {31'd0, if_ready}, 1);
        chk("t1_if_rdata", if_rdata, 32'hDEADBEEF);
        chk("t1_req_drop", {31'd0, mem_req}, 0);
        mem_ack = 0; if_req = 0;
        tick();
        chk("t1_ready_pulse", {31'd0, if_ready}, 0);

        // 2: simultaneous requests, last_grant=IF so ls goes first
        if_req = 1; if_addr = 32'h300;
        ls_req = 1; ls_we = 0; ls_size = 2'b10; ls_addr = 32'h2000;
        tick();
        chk("t2_ls_first_addr", mem_addr, 32'h2000);
        mem_ack = 1; mem_rdata = 32'h11112222;
        tick();
        chk("t2_ls_ready", {31'd0, ls_ready}, 1);
        chk("t2_ls_rdata", ls_rdata, 32'h11112222);
        chk("t2_if_wait", {31'd0, if_ready}, 0);
        ls_req = 0; mem_ack = 0;
        tick();
        chk("t2_if_granted", {31'd0, mem_req}, 1);
        chk("t2_if_addr", mem_addr, 32'h300);
        mem_ack = 1; mem_rdata = 32'h33334444;
        tick();
        chk("t2_if_ready", {31'd0, if_ready}, 1);
        chk("t2_if_rdata", if_rdata, 32'h33334444);
        if_req = 0; mem_ack = 0;
        tick();

        // 3: store byte and store half
        ls_req = 1; ls_we = 1; ls_size = 2'b00; ls_addr = 32'h1003; ls_wdata = 32'h000000AB;
        tick();
        chk("t3b_addr", mem_addr, 32'h1000);
        chk("t3b_be", {28'd0, mem_be}, 4'b1000);
        chk("t3b_wdata", mem_wdata, 32'hABABABAB);
        chk("t3b_we", {31'd0, mem_we}, 1);
        mem_ack = 1;
        tick();
        chk("t3b_ready", {31'd0, ls_ready}, 1);
        ls_req = 0; mem_ack = 0;
        tick();
        ls_req = 1; ls_size = 2'b01; ls_addr = 32'h1002; ls_wdata = 32'h00001234;
        tick();
        chk("t3h_be", {28'd0, mem_be}, 4'b1100);
        chk("t3h_wdata", mem_wdata, 32'h12341234);
        mem_ack = 1;
        tick();
        ls_req = 0; mem_ack = 0;
        tick();

        // 4: swap holds the bus against a pending fetch
        ls_req = 1; ls_we = 0; ls_lock = 1; ls_size = 2'b10; ls_addr = 32'h40;
        tick();
        if_req = 1; if_addr = 32'h500;
        mem_ack = 1; mem_rdata = 32'h00000005;
        tick();
        chk("t4_read_ready", {31'd0, ls_ready}, 1);
        chk("t4_locked_set", {31'd0, locked}, 1);
        ls_req = 0; mem_ack = 0;
        tick();
        chk("t4_if_blocked", {31'd0, mem_req}, 0);
        tick();
        chk("t4_if_still_blocked", {31'd0, mem_req}, 0);
        chk("t4_locked_hold", {31'd0, locked}, 1);
        ls_req = 1; ls_we = 1; ls_lock = 0; ls_wdata = 32'h77;
        tick();
        chk("t4_wr_addr", mem_addr, 32'h40);
        chk("t4_wr_we", {31'd0, mem_we}, 1);
        chk("t4_locked_during_wr", {31'd0, locked}, 1);
        mem_ack = 1;
        tick();
        chk("t4_wr_ready", {31'd0, ls_ready}, 1);
        chk("t4_unlocked", {31'd0, locked}, 0);
        ls_req = 0; mem_ack = 0;
        tick();
        chk("t4_if_now_granted", {31'd0, mem_req}, 1);
        chk("t4_if_addr", mem_addr, 32'h500);
        chk("t4_if_we", {31'd0, mem_we}, 0);
        mem_ack = 1;
        tick();
        chk("t4_if_ready", {31'd0, if_ready}, 1);
        if_req = 0; mem_ack = 0;
        tick();

        // 5: four wait states, then a stray ack while idle
        ls_req = 1; ls_we = 0; ls_size = 2'b01; ls_addr = 32'h89;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t5_req_w%0d", i), {31'd0, mem_req}, 1);
            chk($sformatf("t5_addr_w%0d", i), mem_addr, 32'h88);
            chk($sformatf("t5_be_w%0d", i), {28'd0, mem_be}, 4'b0011);
            chk($sformatf("t5_noready_w%0d", i), {31'd0, ls_ready}, 0);
            tick();
        end
        mem_ack = 1; mem_rdata = 32'hCAFE0000;
        tick();
        chk("t5_ready", {31'd0, ls_ready}, 1);
        chk("t5_rdata", ls_rdata, 32'hCAFE0000);
        ls_req = 0; mem_ack = 0;
        tick();
        chk("t5_single_pulse", {31'd0, ls_ready}, 0);
        mem_ack = 1;
        tick();
        chk("t5_stray_req", {31'd0, mem_req}, 0);
        chk("t5_stray_ready", {30'd0, if_ready, ls_ready}, 0);
        mem_ack = 0;
        tick();

        // 6: asynchronous reset during a locked LS_BUSY
        ls_req = 1; ls_we = 0; ls_lock = 1; ls_size = 2'b10; ls_addr = 32'h60;
        tick();
        mem_ack = 1;
        tick();
        ls_req = 0; mem_ack = 0;
        tick();
        ls_req = 1; ls_we = 1; ls_lock = 0;
        tick();
        chk("t6_busy", {31'd0, mem_req}, 1);
        chk("t6_locked_before", {31'd0, locked}, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_req_drop", {31'd0, mem_req}, 0);
        chk("t6_async_unlock", {31'd0, locked}, 0);
        ls_req = 0; mem_ack = 1;
        tick();
        chk("t6_no_ready", {31'd0, ls_ready}, 0);
        rst = 1'b0; mem_ack = 0;
        tick();
        chk("t6_idle_req", {31'd0, mem_req}, 0);
        chk("t6_locked_after", {31'd0, locked}, 0);
        if_req = 1; if_addr = 32'h700;
        tick();
        chk("t6_if_grant_after", {31'd0, mem_req}, 1);
        chk("t6_if_addr_after", mem_addr, 32'h700);
        if_req = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
